// File: rtl/countdown_ctrl_pkg.sv
// rtl/countdown_ctrl_pkg.sv - shared state encodings and sprite digit codes
//
// Contents:
//   state_t      countdown FSM states (IDLE=0, SHOW3=1, SHOW2=2, SHOW1=3, DONE=4)
//   DIGIT_*      2-bit digit codes understood by the digit sprite renderer
//   digit_of()   maps a countdown state to the digit it displays

package countdown_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SHOW3 = 3'd1,
      ST_SHOW2 = 3'd2,
      ST_SHOW1 = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] DIGIT_BLANK = 2'd0;
   localparam logic [1:0] DIGIT_1     = 2'd1;
   localparam logic [1:0] DIGIT_2     = 2'd2;
   localparam logic [1:0] DIGIT_3     = 2'd3;

   function automatic logic [1:0] digit_of(input state_t s);
      case (s)
         ST_SHOW3: digit_of = DIGIT_3;
         ST_SHOW2: digit_of = DIGIT_2;
         ST_SHOW1: digit_of = DIGIT_1;
         default:  digit_of = DIGIT_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - per-digit dwell timer with exact terminal-count compare
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset
//   en      in   count this cycle (digit on screen and not paused)
//   clr     in   clear the count; wins over en
//   expire  out  count == TICKS_PER_STEP-1 while en is high

module step_timer #(
   parameter int TICKS_PER_STEP = 100000000,
   parameter int CNT_W          = 27
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic expire
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_STEP - 1);

   logic [CNT_W-1:0] count;

   // The owner clears on the same edge expire fires, so the count never
   // runs past LAST and needs no wrap handling.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + CNT_W'(1);
      end
   end

   assign expire = en && (count == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - 3-2-1 start countdown sequencer for the digit sprite
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   start  in   level, sampled only in IDLE, begins a countdown
//   pause  in   level, freezes the dwell timer and holds the digit
//   abort  in   level, returns to IDLE on the next edge from any state
//   num    out  [1:0] digit code to the sprite renderer (3,2,1, 0=blank)
//   show   out  a digit is on screen (SHOW3/SHOW2/SHOW1)
//   busy   out  any state other than IDLE
//   done   out  one-cycle pulse when a countdown completes without abort

module countdown_ctrl
   import countdown_ctrl_pkg::*;
#(
   parameter int TICKS_PER_STEP = 100000000,
   parameter int CNT_W          = 27
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   output logic [1:0] num,
   output logic       show,
   output logic       busy,
   output logic       done
);

   state_t state_q;
   state_t state_d;
   logic   tmr_en;
   logic   tmr_clr;
   logic   expire;

   step_timer #(
      .TICKS_PER_STEP (TICKS_PER_STEP),
      .CNT_W          (CNT_W)
   ) u_step_timer (
      .clk    (clk),
      .rst    (rst),
      .en     (tmr_en),
      .clr    (tmr_clr),
      .expire (expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE:  if (start)  state_d = ST_SHOW3;
            ST_SHOW3: if (expire) state_d = ST_SHOW2;
            ST_SHOW2: if (expire) state_d = ST_SHOW1;
            ST_SHOW1: if (expire) state_d = ST_DONE;
            ST_DONE:              state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
         endcase
      end
   end

   // Outputs decode the registered state only; inputs reach them solely
   // through the state register.
   assign show = (state_q == ST_SHOW3) || (state_q == ST_SHOW2) || (state_q == ST_SHOW1);
   assign num  = digit_of(state_q);
   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

   // Timer runs only while a digit is visible and unpaused, and restarts
   // from zero on every state change so each digit gets a full dwell.
   assign tmr_en  = show && !pause;
   assign tmr_clr = abort || (state_d != state_q);

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - directed self-checking bench for countdown_ctrl

module tb_countdown_ctrl;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       pause;
   logic       abort;
   logic [1:0] num;
   logic       show;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int base_cnt;

   countdown_ctrl #(
      .TICKS_PER_STEP (T),
      .CNT_W          (3)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .pause (pause),
      .abort (abort),
      .num   (num),
      .show  (show),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done) done_cnt++;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Expected digit for sample i of a plain countdown whose start is
   // applied at sample 0: blank, 3 x4, 2 x4, 1 x4, blank (DONE).
   function automatic logic [1:0] plain_num(input int i);
      if (i >= 1 && i <= 12) plain_num = 2'(3 - (i - 1) / 4);
      else                   plain_num = 2'd0;
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_num", 8'(num), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_num", 8'(num), 8'd0);
      chk("idle_show", 8'(show), 8'd0);
      chk("idle_busy", 8'(busy), 8'd0);
      chk("idle_done", 8'(done), 8'd0);

      // plain countdown: done at sample 13
      for (int i = 0; i <= 13; i++) begin
         chk($sformatf("t1_num[%0d]", i), 8'(num), 8'(plain_num(i)));
         chk($sformatf("t1_done[%0d]", i), 8'(done), 8'(i == 13));
         chk($sformatf("t1_show[%0d]", i), 8'(show), 8'(i >= 1 && i <= 12));
         start = (i == 0);
         @(negedge clk);
      end
      chk("t1_busy_after", 8'(busy), 8'd0);
      chk("t1_done_after", 8'(done), 8'd0);
      chk("t1_done_cnt", 8'(done_cnt), 8'd1);

      // pause 5 cycles in SHOW2 after 2 ticks: SHOW2 spans samples 5..13
      for (int i = 0; i <= 18; i++) begin
         logic [1:0] en;
         if (i == 0 || i == 18)    en = 2'd0;
         else if (i <= 4)          en = 2'd3;
         else if (i <= 13)         en = 2'd2;
         else                      en = 2'd1;
         chk($sformatf("t2_num[%0d]", i), 8'(num), 8'(en));
         chk($sformatf("t2_done[%0d]", i), 8'(done), 8'(i == 18));
         chk($sformatf("t2_show[%0d]", i), 8'(show), 8'(i >= 1 && i <= 17));
         start = (i == 0);
         pause = (i >= 7 && i <= 11);
         @(negedge clk);
      end
      pause = 1'b0;
      chk("t2_busy_after", 8'(busy), 8'd0);

      // abort in SHOW1 (sample 10), restart with a one-cycle gap
      base_cnt = done_cnt;
      for (int i = 0; i <= 10; i++) begin
         start = (i == 0);
         abort = (i == 10);
         @(negedge clk);
      end
      chk("t3_num", 8'(num), 8'd0);
      chk("t3_busy", 8'(busy), 8'd0);
      abort = 1'b0;
      @(negedge clk);
      chk("t3_gap_num", 8'(num), 8'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("t3_restart_num", 8'(num), 8'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t3_abort2_busy", 8'(busy), 8'd0);
      @(negedge clk);
      chk("t3_no_done", 8'(done_cnt - base_cnt), 8'd0);

      // start held high for 40 cycles: period 14 (12 show, DONE, 1 IDLE)
      base_cnt = done_cnt;
      start = 1'b1;
      for (int j = 0; j < 40; j++) begin
         int p;
         p = j % 14;
         chk($sformatf("t4_num[%0d]", j), 8'(num), 8'(plain_num(p)));
         chk($sformatf("t4_done[%0d]", j), 8'(done), 8'(p == 13));
         chk($sformatf("t4_busy[%0d]", j), 8'(busy), 8'(p != 0));
         @(negedge clk);
      end
      start = 1'b0;
      chk("t4_done_cnt", 8'(done_cnt - base_cnt), 8'd2);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      @(negedge clk);

      // async reset mid-SHOW3, between clock edges
      base_cnt = done_cnt;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t5_pre_num", 8'(num), 8'd3);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("t5_async_num", 8'(num), 8'd0);
      chk("t5_async_show", 8'(show), 8'd0);
      chk("t5_async_busy", 8'(busy), 8'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("t5_idle_busy[%0d]", i), 8'(busy), 8'd0);
      end
      chk("t5_no_done", 8'(done_cnt - base_cnt), 8'd0);

      // start and abort together in IDLE
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      chk("t6_num", 8'(num), 8'd0);
      chk("t6_busy", 8'(busy), 8'd0);
      abort = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("t6_enter_num", 8'(num), 8'd3);
      chk("t6_enter_show", 8'(show), 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
